// File: rtl/ysyx_22040759_gpr_mp.sv
// Multi-port GPR with two write lanes, optional write-to-read bypass and a
// per-register busy scoreboard used by issue (set) and writeback (clear).
module ysyx_22040759_gpr_mp #(
    parameter int XLEN   = 32,
    parameter int AW     = 5,
    parameter int NRD    = 2,
    parameter int BYPASS = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NRD*AW-1:0]     raddr,
    output logic [NRD*XLEN-1:0]   rdata,
    output logic [NRD-1:0]        rbusy,
    input  logic                  wen0,
    input  logic [AW-1:0]         waddr0,
    input  logic [XLEN-1:0]       wdata0,
    input  logic                  wen1,
    input  logic [AW-1:0]         waddr1,
    input  logic [XLEN-1:0]       wdata1,
    input  logic                  iss_valid,
    input  logic [AW-1:0]         iss_rd,
    input  logic                  flush,
    input  logic [AW-1:0]         dbg_raddr,
    output logic [XLEN-1:0]       dbg_rdata,
    output logic [(2**AW)-1:0]    busy_vec
);

    localparam int NREG = 2**AW;

    logic [XLEN-1:0] regs [NREG];
    logic [NREG-1:0] busy;
    logic [NREG-1:0] busy_nxt;

    // Lane 1 is the younger instruction, so its write lands last and wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (wen0 && (waddr0 != '0)) regs[waddr0] <= wdata0;
            if (wen1 && (waddr1 != '0)) regs[waddr1] <= wdata1;
        end
    end

    // A same-cycle issue beats a writeback clear: the new producer supersedes.
    always_comb begin
        busy_nxt = busy;
        if (flush) begin
            busy_nxt = '0;
        end else begin
            for (int r = 1; r < NREG; r++) begin
                if (iss_valid && (iss_rd == AW'(r))) begin
                    busy_nxt[r] = 1'b1;
                end else if ((wen0 && (waddr0 == AW'(r))) ||
                             (wen1 && (waddr1 == AW'(r)))) begin
                    busy_nxt[r] = 1'b0;
                end
            end
        end
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) busy <= '0;
        else     busy <= busy_nxt;
    end

    always_comb begin
        rdata = '0;
        rbusy = '0;
        for (int k = 0; k < NRD; k++) begin
            logic [AW-1:0] ra;
            logic          hit0;
            logic          hit1;
            ra   = raddr[k*AW +: AW];
            hit0 = wen0 && (waddr0 == ra);
            hit1 = wen1 && (waddr1 == ra);
            if (ra != '0) begin
                if (BYPASS != 0) begin
                    if (hit1)      rdata[k*XLEN +: XLEN] = wdata1;
                    else if (hit0) rdata[k*XLEN +: XLEN] = wdata0;
                    else           rdata[k*XLEN +: XLEN] = regs[ra];
                    rbusy[k] = busy[ra] && !(hit0 || hit1);
                end else begin
                    rdata[k*XLEN +: XLEN] = regs[ra];
                    rbusy[k] = busy[ra];
                end
            end
        end
    end

    assign dbg_rdata = (dbg_raddr == '0) ? '0 : regs[dbg_raddr];
    assign busy_vec  = busy;

endmodule

// File: tb/tb_ysyx_22040759_gpr_mp.sv
// Bench for ysyx_22040759_gpr_mp: a bypassing and a non-bypassing instance
// share stimulus; expectations are queued per cycle and checked by a monitor.
module tb_ysyx_22040759_gpr_mp;

    localparam int XLEN = 32;
    localparam int AW   = 5;
    localparam int NRD  = 2;

    localparam int K_RD0  = 0;
    localparam int K_RD1  = 1;
    localparam int K_RB0  = 2;
    localparam int K_RB1  = 3;
    localparam int K_BV   = 4;
    localparam int K_DBG  = 5;
    localparam int K_NRD0 = 6;
    localparam int K_NRB0 = 7;

    logic                clk;
    logic                rst;
    logic [NRD*AW-1:0]   raddr;
    logic [NRD*XLEN-1:0] rdata, rdata_nb;
    logic [NRD-1:0]      rbusy, rbusy_nb;
    logic                wen0, wen1, iss_valid, flush;
    logic [AW-1:0]       waddr0, waddr1, iss_rd, dbg_raddr;
    logic [XLEN-1:0]     wdata0, wdata1, dbg_rdata, dbg_rdata_nb;
    logic [31:0]         busy_vec, busy_vec_nb;

    ysyx_22040759_gpr_mp #(.XLEN(XLEN), .AW(AW), .NRD(NRD), .BYPASS(1)) dut (
        .clk(clk), .rst(rst), .raddr(raddr), .rdata(rdata), .rbusy(rbusy),
        .wen0(wen0), .waddr0(waddr0), .wdata0(wdata0),
        .wen1(wen1), .waddr1(waddr1), .wdata1(wdata1),
        .iss_valid(iss_valid), .iss_rd(iss_rd), .flush(flush),
        .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_rdata), .busy_vec(busy_vec)
    );

    ysyx_22040759_gpr_mp #(.XLEN(XLEN), .AW(AW), .NRD(NRD), .BYPASS(0)) dut_nb (
        .clk(clk), .rst(rst), .raddr(raddr), .rdata(rdata_nb), .rbusy(rbusy_nb),
        .wen0(wen0), .waddr0(waddr0), .wdata0(wdata0),
        .wen1(wen1), .waddr1(waddr1), .wdata1(wdata1),
        .iss_valid(iss_valid), .iss_rd(iss_rd), .flush(flush),
        .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_rdata_nb), .busy_vec(busy_vec_nb)
    );

    typedef struct {
        int          cyc;
        int          kind;
        logic [31:0] exp;
        string       name;
    } exp_t;

    exp_t sbq[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    bool_t_dummy_unused_guard guard_unused();

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    function automatic logic [31:0] actual(input int kind);
        case (kind)
            K_RD0:   return rdata[31:0];
            K_RD1:   return rdata[63:32];
            K_RB0:   return {31'b0, rbusy[0]};
            K_RB1:   return {31'b0, rbusy[1]};
            K_BV:    return busy_vec;
            K_DBG:   return dbg_rdata;
            K_NRD0:  return rdata_nb[31:0];
            K_NRB0:  return {31'b0, rbusy_nb[0]};
            default: return 32'hxxxx_xxxx;
        endcase
    endfunction

    task automatic expect_now(input int kind, input logic [31:0] exp, input string name);
        exp_t e;
        e.cyc  = cyc;
        e.kind = kind;
        e.exp  = exp;
        e.name = name;
        sbq.push_back(e);
    endtask

    // Monitor: outputs are combinational, so they are sampled mid-low-phase,
    // after the driver has applied this cycle's inputs at the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            for (int i = sbq.size() - 1; i >= 0; i--) begin
                if (sbq[i].cyc == cyc) begin
                    logic [31:0] a;
                    a = actual(sbq[i].kind);
                    checks++;
                    if (a !== sbq[i].exp) begin
                        errors++;
                        $display("FAIL %s cyc=%0d got=%h want=%h", sbq[i].name, cyc, a, sbq[i].exp);
                    end
                    sbq.delete(i);
                end
            end
        end
    end

    task automatic step(input logic [AW-1:0] r0, input logic [AW-1:0] r1);
        @(negedge clk);
        rst = 0; wen0 = 0; wen1 = 0; iss_valid = 0; flush = 0;
        waddr0 = '0; waddr1 = '0; wdata0 = '0; wdata1 = '0; iss_rd = '0;
        raddr = {r1, r0};
        dbg_raddr = r0;
    endtask

    initial begin
        rst = 1; wen0 = 0; wen1 = 0; iss_valid = 0; flush = 0;
        waddr0 = '0; waddr1 = '0; wdata0 = '0; wdata1 = '0; iss_rd = '0;
        raddr = '0; dbg_raddr = '0;

        // After reset
        step(5, 8);
        expect_now(K_BV, 32'h0, "rst_busy_vec");
        expect_now(K_RD0, 32'h0, "rst_rdata0");
        expect_now(K_RB0, 32'h0, "rst_rbusy0");
        expect_now(K_DBG, 32'h0, "rst_dbg");

        // Write x5, issue x6
        step(5, 6);
        wen0 = 1; waddr0 = 5; wdata0 = 32'hDEADBEEF;
        iss_valid = 1; iss_rd = 6;
        expect_now(K_RD0, 32'hDEADBEEF, "bypass_x5");
        expect_now(K_NRD0, 32'h0, "nobypass_x5_old");
        expect_now(K_RB1, 32'h0, "iss_same_cycle_rbusy");

        // Reset cycle with in-flight write and issue that must be lost
        step(5, 6);
        rst = 1;
        wen1 = 1; waddr1 = 8; wdata1 = 32'h77;
        iss_valid = 1; iss_rd = 10;
        expect_now(K_RD0, 32'hDEADBEEF, "pre_rst_x5");
        expect_now(K_BV, 32'h0000_0040, "pre_rst_busy6");
        expect_now(K_RB1, 32'h1, "pre_rst_rbusy6");

        step(5, 8);
        expect_now(K_RD0, 32'h0, "post_rst_x5");
        expect_now(K_RD1, 32'h0, "post_rst_x8_lost");
        expect_now(K_BV, 32'h0, "post_rst_busy");

        // x0 protection
        step(0, 0);
        wen0 = 1; waddr0 = 0; wdata0 = 32'h1234;
        iss_valid = 1; iss_rd = 0;
        expect_now(K_RD0, 32'h0, "x0_bypass");
        expect_now(K_RB0, 32'h0, "x0_rbusy");

        step(0, 0);
        expect_now(K_RD0, 32'h0, "x0_read");
        expect_now(K_BV, 32'h0, "x0_busy_vec");
        expect_now(K_DBG, 32'h0, "x0_dbg");

        // Independent lanes, then dual-write conflict on x7
        step(3, 7);
        wen0 = 1; waddr0 = 7; wdata0 = 32'hAA;
        wen1 = 1; waddr1 = 3; wdata1 = 32'h33;
        expect_now(K_RD0, 32'h33, "lane1_bypass_x3");
        expect_now(K_RD1, 32'hAA, "lane0_bypass_x7");

        step(7, 7);
        wen0 = 1; waddr0 = 7; wdata0 = 32'h11;
        wen1 = 1; waddr1 = 7; wdata1 = 32'h22;
        expect_now(K_RD0, 32'h22, "conflict_bypass0");
        expect_now(K_RD1, 32'h22, "conflict_bypass1");
        expect_now(K_NRD0, 32'hAA, "conflict_nb_old");

        step(7, 3);
        expect_now(K_RD0, 32'h22, "conflict_stored");
        expect_now(K_NRD0, 32'h22, "conflict_nb_stored");
        expect_now(K_DBG, 32'h22, "conflict_dbg");
        expect_now(K_RD1, 32'h33, "x3_stored");

        // Scoreboard lifecycle on x9
        step(9, 0);
        iss_valid = 1; iss_rd = 9;
        expect_now(K_RB0, 32'h0, "life_c0_rbusy");
        expect_now(K_NRB0, 32'h0, "life_c0_nb_rbusy");
        step(9, 0);
        expect_now(K_RB0, 32'h1, "life_c1_rbusy");
        expect_now(K_NRB0, 32'h1, "life_c1_nb_rbusy");
        expect_now(K_BV, 32'h0000_0200, "life_c1_busy_vec");
        step(9, 0);
        expect_now(K_RB0, 32'h1, "life_c2_rbusy");
        step(9, 0);
        wen0 = 1; waddr0 = 9; wdata0 = 32'h55;
        expect_now(K_RB0, 32'h0, "life_c3_rbusy");
        expect_now(K_NRB0, 32'h1, "life_c3_nb_rbusy");
        expect_now(K_RD0, 32'h55, "life_c3_rdata");
        expect_now(K_BV, 32'h0000_0200, "life_c3_busy_vec");
        step(9, 0);
        expect_now(K_RB0, 32'h0, "life_c4_rbusy");
        expect_now(K_NRB0, 32'h0, "life_c4_nb_rbusy");
        expect_now(K_BV, 32'h0, "life_c4_busy_vec");
        expect_now(K_DBG, 32'h55, "life_c4_dbg");

        // Set/clear collision on x12, then flush with concurrent issue
        step(12, 0);
        iss_valid = 1; iss_rd = 12;
        wen1 = 1; waddr1 = 12; wdata1 = 32'h99;
        expect_now(K_RD0, 32'h99, "coll_bypass");
        step(12, 0);
        expect_now(K_BV, 32'h0000_1000, "coll_busy12");
        expect_now(K_RB0, 32'h1, "coll_rbusy12");
        expect_now(K_RD0, 32'h99, "coll_data");
        step(12, 0);
        flush = 1; iss_valid = 1; iss_rd = 13;
        expect_now(K_BV, 32'h0000_1000, "flush_cycle_busy");
        step(12, 0);
        expect_now(K_BV, 32'h0, "flush_busy_vec");
        expect_now(K_RD0, 32'h99, "flush_keeps_data");
        expect_now(K_DBG, 32'h99, "flush_dbg");

        // Lane 1 writeback clears busy
        step(0, 14);
        iss_valid = 1; iss_rd = 14;
        step(0, 14);
        wen1 = 1; waddr1 = 14; wdata1 = 32'h14;
        expect_now(K_RB1, 32'h0, "wb1_rbusy_bypass");
        expect_now(K_BV, 32'h0000_4000, "wb1_busy_before");
        expect_now(K_RD1, 32'h14, "wb1_bypass_data");
        step(0, 14);
        expect_now(K_BV, 32'h0, "wb1_busy_after");
        expect_now(K_RD1, 32'h14, "wb1_stored");

        step(0, 0);
        step(0, 0);
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got=%0d pending want=0", sbq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

module bool_t_dummy_unused_guard;
endmodule
